// File: rtl/fbcpu_program_memory_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fbcpu_program_memory_if : core bus + boot-loader stream for the FBCPU RAM
// Rev 1.0
// ---------------------------------------------------------------------------
interface fbcpu_program_memory_if #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 10
);
  logic [ADDRESS_WIDTH-1:0] cpu_mar;
  logic                     cpu_wr;
  logic [DATA_WIDTH-1:0]    cpu_wdata;
  logic [DATA_WIDTH-1:0]    cpu_rdata;
  logic                     cpu_rst;
  logic                     ld_start;
  logic                     ld_valid;
  logic [DATA_WIDTH-1:0]    ld_data;
  logic                     ld_last;
  logic                     ld_ready;
  logic [ADDRESS_WIDTH:0]   ld_count;
  logic                     ld_overflow;
  logic [DATA_WIDTH-1:0]    ld_checksum;

  modport slave (
    input  cpu_mar, cpu_wr, cpu_wdata, ld_start, ld_valid, ld_data, ld_last,
    output cpu_rdata, cpu_rst, ld_ready, ld_count, ld_overflow, ld_checksum
  );

  modport master (
    output cpu_mar, cpu_wr, cpu_wdata, ld_start, ld_valid, ld_data, ld_last,
    input  cpu_rdata, cpu_rst, ld_ready, ld_count, ld_overflow, ld_checksum
  );
endinterface
`default_nettype wire

// File: rtl/fbcpu_program_memory.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fbcpu_program_memory : FBCPU program/data RAM with clear + boot-load sequencer
// Optional macro FBCPU_LD_CHECKSUM_EN enables the load checksum.  Rev 1.0
// ---------------------------------------------------------------------------
module fbcpu_program_memory #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 10
) (
  input  wire logic               clk,
  input  wire logic               rst,
  fbcpu_program_memory_if.slave   bus
);
  localparam int                       c_DEPTH     = 2**ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] c_LAST_ADDR = '1;
`ifdef FBCPU_LD_CHECKSUM_EN
  localparam bit c_CHECKSUM_EN = 1'b1;
`else
  localparam bit c_CHECKSUM_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t                   r_state;
  logic [DATA_WIDTH-1:0]    r_mem [c_DEPTH];
  logic [ADDRESS_WIDTH-1:0] r_clr_addr;
  logic [ADDRESS_WIDTH-1:0] r_ld_addr;
  logic [DATA_WIDTH-1:0]    r_cpu_rdata;
  logic                     r_cpu_rst;
  logic                     r_ld_ready;
  logic [ADDRESS_WIDTH:0]   r_ld_count;
  logic                     r_ld_overflow;
  logic [DATA_WIDTH-1:0]    r_ld_checksum;

  logic                     w_xfer;
  logic                     w_mem_we;
  logic [ADDRESS_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0]    w_mem_wdata;

  assign w_xfer = (r_state == ST_LOAD) && r_ld_ready && bus.ld_valid;

  // Single write port shared by the clear sweep, the loader and the core.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = bus.cpu_mar;
    w_mem_wdata = bus.cpu_wdata;
    if (!rst) begin
      case (r_state)
        ST_CLEAR: begin
          w_mem_we    = 1'b1;
          w_mem_addr  = r_clr_addr;
          w_mem_wdata = '0;
        end
        ST_LOAD: begin
          w_mem_we    = w_xfer;
          w_mem_addr  = r_ld_addr;
          w_mem_wdata = bus.ld_data;
        end
        ST_RUN:  w_mem_we = bus.cpu_wr;
        default: w_mem_we = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_CLEAR;
      r_clr_addr    <= '0;
      r_ld_addr     <= '0;
      r_cpu_rdata   <= '0;
      r_cpu_rst     <= 1'b1;
      r_ld_ready    <= 1'b0;
      r_ld_count    <= '0;
      r_ld_overflow <= 1'b0;
      r_ld_checksum <= '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_cpu_rdata <= '0;
          if (r_clr_addr == c_LAST_ADDR) begin
            r_state    <= ST_LOAD;
            r_ld_ready <= 1'b1;
          end else begin
            r_clr_addr <= r_clr_addr + ADDRESS_WIDTH'(1);
          end
        end
        ST_LOAD: begin
          r_cpu_rdata <= '0;
          if (w_xfer) begin
            r_ld_count <= r_ld_count + (ADDRESS_WIDTH+1)'(1);
            if (c_CHECKSUM_EN) r_ld_checksum <= r_ld_checksum + bus.ld_data;
            // Last address ends the load even without ld_last; flag it as overflow.
            if (bus.ld_last || (r_ld_addr == c_LAST_ADDR)) begin
              r_state       <= ST_RUN;
              r_ld_ready    <= 1'b0;
              r_cpu_rst     <= 1'b0;
              r_ld_overflow <= !bus.ld_last;
            end else begin
              r_ld_addr <= r_ld_addr + ADDRESS_WIDTH'(1);
            end
          end
        end
        ST_RUN: begin
          if (bus.ld_start) begin
            r_state       <= ST_CLEAR;
            r_cpu_rst     <= 1'b1;
            r_cpu_rdata   <= '0;
            r_clr_addr    <= '0;
            r_ld_addr     <= '0;
            r_ld_count    <= '0;
            r_ld_overflow <= 1'b0;
            r_ld_checksum <= '0;
          end else begin
            r_cpu_rdata <= r_mem[bus.cpu_mar];
          end
        end
        default: begin
          r_state   <= ST_CLEAR;
          r_cpu_rst <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cpu_rdata   = r_cpu_rdata;
  assign bus.cpu_rst     = r_cpu_rst;
  assign bus.ld_ready    = r_ld_ready;
  assign bus.ld_count    = r_ld_count;
  assign bus.ld_overflow = r_ld_overflow;
  assign bus.ld_checksum = r_ld_checksum;

endmodule
`default_nettype wire
